exibe_sequencia: RTL and testbench

//  Plays back the stored move sequence to the player, which is the output side of the game datapath.
//  On each start it reads game memory from address 0 up to the current round.

---
 rtl/exibe_sequencia_pkg.sv | 23 ++
 rtl/exibe_sequencia_contador_m.sv | 30 +++
 rtl/exibe_sequencia.sv | 109 ++++++++++
 tb/tb_exibe_sequencia.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the move-playback block; the state codes are also
// decoded by the game control unit for its debug display.
package exibe_sequencia_pkg;

   localparam int ADDR_W_PADRAO = 4;
   localparam int DATA_W_PADRAO = 4;

   typedef enum logic [3:0] {
      OCIOSO  = 4'h0,
      CARREGA = 4'h1,
      ACENDE  = 4'h2,
      APAGA   = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'h5
   } estado_t;

   localparam logic [3:0] ESTADO_INVALIDO = 4'hF;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/exibe_sequencia_contador_m.sv
// Generic mod-M counter with synchronous clear (zera), enable (conta) and
// terminal-count flag (fim).
module contador_m #(
   parameter int M = 4,
   localparam int W = (M > 1) ? $clog2(M) : 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [W-1:0] valor,
   output logic         fim
);

   localparam logic [W-1:0] ULTIMO = W'(M - 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor <= '0;
      end else if (zera) begin
         valor <= '0;
      end else if (conta) begin
         // NOTE: registers are updated with <= so every flop samples pre-edge values.
         valor <= (valor == ULTIMO) ? '0 : valor + 1'b1;
      end
   end

   assign fim = (valor == ULTIMO);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays back stored moves from address 0 up to the latched round: each move is
// lit for T_ACESO cycles, then blanked for T_APAGADO cycles; pronto pulses at the end.
module exibe_sequencia
   import exibe_sequencia_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_PADRAO,
   parameter int DATA_W    = DATA_W_PADRAO,
   parameter int T_ACESO   = 3,
   parameter int T_APAGADO = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              parar,
   input  logic [ADDR_W-1:0] rodada,
   input  logic [DATA_W-1:0] dado_mem,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   localparam int T_MAX = maxInt(T_ACESO, T_APAGADO);
   localparam int TW    = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] ULT_ACESO   = TW'(T_ACESO - 1);
   localparam logic [TW-1:0] ULT_APAGADO = TW'(T_APAGADO - 1);

   estado_t           estado;
   logic [ADDR_W-1:0] contEndereco;
   logic [ADDR_W-1:0] rodadaReg;
   logic [DATA_W-1:0] movimento;
   logic [TW-1:0]     timer;
   logic              fimTimer;
   logic              zeraTimer;
   logic              contaTimer;

   // Timer restarts entering each lit/blank phase; fimTimer keeps it from wrapping.
   assign zeraTimer  = (estado == CARREGA) || ((estado == ACENDE) && (timer == ULT_ACESO));
   assign contaTimer = ((estado == ACENDE) || (estado == APAGA)) && !fimTimer;

   contador_m #(.M(T_MAX + 1)) timerLed (
      .clock (clock),
      .reset (reset),
      .zera  (zeraTimer),
      .conta (contaTimer),
      .valor (timer),
      .fim   (fimTimer)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: every state register, including the data latches, gets the async reset.
         estado       <= OCIOSO;
         contEndereco <= '0;
         rodadaReg    <= '0;
         movimento    <= '0;
      end else if (parar) begin
         estado <= OCIOSO;
      end else begin
         case (estado)
            OCIOSO: begin
               if (iniciar) begin
                  estado       <= CARREGA;
                  rodadaReg    <= rodada;
                  contEndereco <= '0;
               end
            end
            CARREGA: begin
               movimento <= dado_mem;
               estado    <= ACENDE;
            end
            ACENDE: begin
               if (timer == ULT_ACESO) estado <= APAGA;
            end
            APAGA: begin
               if (timer == ULT_APAGADO) estado <= PROXIMO;
            end
            PROXIMO: begin
               // Compare before incrementing so the last address never wraps.
               if (contEndereco == rodadaReg) begin
                  estado <= FIM;
               end else begin
                  contEndereco <= contEndereco + 1'b1;
                  estado       <= CARREGA;
               end
            end
            FIM:     estado <= OCIOSO;
            default: estado <= OCIOSO;
         endcase
      end
   end

   // Moore outputs decoded from registered state, so reset blanks them at once.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      db_estado = ESTADO_INVALIDO;
      case (estado)
         OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FIM: db_estado = estado;
         default:                                       db_estado = ESTADO_INVALIDO;
      endcase
   end

   assign endereco = contEndereco;
   assign leds     = (estado == ACENDE) ? movimento : '0;
   assign ocupado  = (estado != OCIOSO);
   assign pronto   = (estado == FIM);

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia: cycle-by-cycle comparison against a
// trace model built from the playback rules, with randomized memories and rounds.
module tb_exibe_sequencia;

   localparam int T_A   = 3;
   localparam int T_P   = 2;
   localparam int PASSO = 1 + T_A + T_P + 1;

   typedef struct packed {
      logic [3:0] leds;
      logic [3:0] endereco;
      logic [3:0] estado;
      logic       ocupado;
      logic       pronto;
   } obs_t;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       parar;
   logic [3:0] rodada;
   logic [3:0] dadoMem;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] dbEstado;

   logic [3:0] mem [16];
   obs_t       esperado [$];
   int         total;
   int         falhas;

   // Asynchronous-read game memory: data follows the address within the cycle.
   assign dadoMem = mem[endereco];

   exibe_sequencia #(.ADDR_W(4), .DATA_W(4), .T_ACESO(T_A), .T_APAGADO(T_P)) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .parar     (parar),
      .rodada    (rodada),
      .dado_mem  (dadoMem),
      .endereco  (endereco),
      .leds      (leds),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .db_estado (dbEstado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t observa();
      obs_t o;
      o.leds     = leds;
      o.endereco = endereco;
      o.estado   = dbEstado;
      o.ocupado  = ocupado;
      o.pronto   = pronto;
      return o;
   endfunction

   function automatic obs_t mk(input logic [3:0] l, input logic [3:0] e, input logic [3:0] s,
                               input logic oc, input logic pr);
      obs_t o;
      o.leds = l; o.endereco = e; o.estado = s; o.ocupado = oc; o.pronto = pr;
      return o;
   endfunction

   // Expected trace from the first cycle after the start edge through FIM.
   function automatic void montaEsperado(input logic [3:0] rod);
      esperado.delete();
      for (int i = 0; i <= int'(rod); i++) begin
         esperado.push_back(mk(4'h0, 4'(i), 4'h1, 1'b1, 1'b0));
         for (int k = 0; k < T_A; k++) esperado.push_back(mk(mem[i], 4'(i), 4'h2, 1'b1, 1'b0));
         for (int k = 0; k < T_P; k++) esperado.push_back(mk(4'h0, 4'(i), 4'h3, 1'b1, 1'b0));
         esperado.push_back(mk(4'h0, 4'(i), 4'h4, 1'b1, 1'b0));
      end
      esperado.push_back(mk(4'h0, rod, 4'h5, 1'b1, 1'b1));
   endfunction

   task automatic compara(input string nome, input int ciclo, input obs_t exp_o);
      obs_t o;
      o = observa();
      total++;
      if (o !== exp_o) begin
         falhas++;
         $display("FAIL %s cycle %0d: got leds=%h end=%h st=%h busy=%b pronto=%b, want leds=%h end=%h st=%h busy=%b pronto=%b",
                  nome, ciclo, o.leds, o.endereco, o.estado, o.ocupado, o.pronto,
                  exp_o.leds, exp_o.endereco, exp_o.estado, exp_o.ocupado, exp_o.pronto);
      end
   endtask

   task automatic esperaOcioso(input string nome);
      int n;
      n = 0;
      while (ocupado !== 1'b0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (ocupado !== 1'b0) begin
         total++;
         falhas++;
         $display("FAIL %s: ocupado=%b after 300 cycles, want 0", nome, ocupado);
      end
   endtask

   // Full playback; perturba pulses iniciar and changes rodada to 5 mid-run.
   task automatic runPlayback(input logic [3:0] rod, input bit perturba, input string nome);
      montaEsperado(rod);
      @(negedge clock);
      iniciar = 1'b1;
      rodada  = rod;
      @(negedge clock);
      iniciar = 1'b0;
      for (int i = 0; i < esperado.size(); i++) begin
         if (perturba && i == 8) begin
            iniciar = 1'b1;
            rodada  = 4'd5;
         end
         if (perturba && i == 9) iniciar = 1'b0;
         compara(nome, i + 1, esperado[i]);
         @(negedge clock);
      end
      compara({nome, "_idle"}, esperado.size() + 1, mk(4'h0, rod, 4'h0, 1'b0, 1'b0));
      esperaOcioso(nome);
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      iniciar = 1'b0;
      parar   = 1'b0;
      rodada  = 4'd0;
      repeat (2) @(negedge clock);
      compara("reset_hold", 0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      reset = 1'b0;
      @(negedge clock);
      compara("reset_release", 1, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
   endtask

   task automatic test_basico();
      mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
      runPlayback(4'd2, 1'b0, "three_moves");
      mem[0] = 4'h8;
      runPlayback(4'd0, 1'b0, "single_move");
   endtask

   task automatic test_parar();
      mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
      @(negedge clock);
      iniciar = 1'b1;
      rodada  = 4'd2;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (8) @(negedge clock);
      compara("abort_in_2nd_acende", 9, mk(4'h2, 4'h1, 4'h2, 1'b1, 1'b0));
      parar = 1'b1;
      @(negedge clock);
      parar = 1'b0;
      for (int i = 0; i < 4; i++) begin
         compara("abort_idle", i, mk(4'h0, 4'h1, 4'h0, 1'b0, 1'b0));
         @(negedge clock);
      end
      runPlayback(4'd2, 1'b0, "replay_after_abort");
      // Start blocked while parar is high.
      iniciar = 1'b1;
      parar   = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      parar   = 1'b0;
      compara("start_with_parar", 0, mk(4'h0, 4'h2, 4'h0, 1'b0, 1'b0));
   endtask

   task automatic test_ignora_entradas();
      mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
      runPlayback(4'd2, 1'b1, "ignore_iniciar_rodada");
   endtask

   task automatic test_reset_async();
      mem[0] = 4'h4; mem[1] = 4'h8;
      @(negedge clock);
      iniciar = 1'b1;
      rodada  = 4'd1;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (12) @(negedge clock);
      compara("in_2nd_apaga", 13, mk(4'h0, 4'h1, 4'h3, 1'b1, 1'b0));
      #2 reset = 1'b1;
      #1 compara("async_reset_now", 13, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         compara("post_reset_idle", i, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_rodada_maxima();
      for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
      runPlayback(4'd15, 1'b0, "all_addresses");
   endtask

   task automatic test_aleatorio();
      logic [3:0] rod;
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << $urandom_range(0, 3);
         rod = 4'($urandom_range(0, 15));
         runPlayback(rod, 1'($urandom_range(0, 1)) && (rod >= 4'd2), "random_playback");
      end
   endtask

   initial begin
      total  = 0;
      falhas = 0;
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      test_reset();
      test_basico();
      test_parar();
      test_ignora_entradas();
      test_reset_async();
      test_rodada_maxima();
      test_aleatorio();
      $display("[TB] %0d tests run, %0d failed", total, falhas);
      $finish;
   end

endmodule
